// File: rtl/ui_dvp_pkg.sv
// Shared types and constants for the RGB565 -> 8-bit DVP camera-bus transmitter.
// Byte order lives here so the top-level mux and any future receiver agree.
package ui_dvp_pkg;

  localparam int CNT_W         = 12;
  localparam bit HI_BYTE_FIRST = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_LINE,
    ST_HBLANK,
    ST_VFRONT
  } dvp_state_e;

  function automatic logic [7:0] first_byte(input logic [15:0] px);
    return HI_BYTE_FIRST ? px[15:8] : px[7:0];
  endfunction

  function automatic logic [7:0] second_byte(input logic [15:0] px);
    return HI_BYTE_FIRST ? px[7:0] : px[15:8];
  endfunction

endpackage

// File: rtl/ui_dvp_rgb565_tx_if.sv
// Pixel stream in, DVP byte bus out. The transmitter is the slave of the
// pixel stream; whoever feeds pixels and watches the bus is the master.
interface ui_dvp_rgb565_tx_if;
  logic [15:0] pix_data_i;
  logic        pix_valid_i;
  logic        pix_ready_o;
  logic        cmos_vsync_o;
  logic        cmos_href_o;
  logic [7:0]  cmos_data_o;

  modport master (
    output pix_data_i, pix_valid_i,
    input  pix_ready_o, cmos_vsync_o, cmos_href_o, cmos_data_o
  );

  modport slave (
    input  pix_data_i, pix_valid_i,
    output pix_ready_o, cmos_vsync_o, cmos_href_o, cmos_data_o
  );
endinterface

// File: rtl/ui_dvp_timing_gen.sv
// Frame/line timing FSM. Its state runs one cycle ahead of the registered DVP
// outputs, so the top simply registers a decode of state_o.
module ui_dvp_timing_gen
  import ui_dvp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 144,
  parameter int VS_WIDTH = 4,
  parameter int VS_BACK  = 16,
  parameter int VS_FRONT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  output dvp_state_e state_o,
  output logic       phase_o,
  output logic       line_end_o,
  output logic       frame_end_o,
  output logic       vs_start_o
);

  localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(2*H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VSW_LAST  = CNT_W'(VS_WIDTH - 1);
  localparam logic [CNT_W-1:0] VSB_LAST  = CNT_W'(VS_BACK - 1);
  localparam logic [CNT_W-1:0] HB_LAST   = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] VSF_LAST  = CNT_W'(VS_FRONT - 1);

  dvp_state_e       state_q, state_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic [CNT_W-1:0] line_q, line_d;
  logic [CNT_W-1:0] blk_q, blk_d;
  logic [CNT_W-1:0] blk_last;
  logic             blk_end;
  logic             pix_end;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pix_q   <= '0;
      line_q  <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      blk_q   <= blk_d;
    end
  end

  // One blanking counter is shared by every non-active phase.
  always_comb begin
    blk_last = '0;
    case (state_q)
      ST_VSYNC:  blk_last = VSW_LAST;
      ST_VBACK:  blk_last = VSB_LAST;
      ST_HBLANK: blk_last = HB_LAST;
      ST_VFRONT: blk_last = VSF_LAST;
      default:   blk_last = '0;
    endcase
  end

  assign blk_end = (blk_q == blk_last);
  assign pix_end = (pix_q == PIX_LAST);

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    line_d      = line_q;
    blk_d       = blk_q;
    line_end_o  = 1'b0;
    frame_end_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pix_d  = '0;
        line_d = '0;
        blk_d  = '0;
        if (en_i) state_d = ST_VSYNC;
      end
      ST_VSYNC: begin
        blk_d = blk_end ? '0 : blk_q + 1'b1;
        if (blk_end) state_d = ST_VBACK;
      end
      ST_VBACK: begin
        blk_d = blk_end ? '0 : blk_q + 1'b1;
        if (blk_end) begin
          state_d = ST_LINE;
          line_d  = '0;
          pix_d   = '0;
        end
      end
      ST_LINE: begin
        pix_d = pix_end ? '0 : pix_q + 1'b1;
        if (pix_end) begin
          line_end_o = 1'b1;
          state_d    = (line_q < LINE_LAST) ? ST_HBLANK : ST_VFRONT;
        end
      end
      ST_HBLANK: begin
        blk_d = blk_end ? '0 : blk_q + 1'b1;
        if (blk_end) begin
          state_d = ST_LINE;
          line_d  = line_q + 1'b1;
        end
      end
      ST_VFRONT: begin
        blk_d = blk_end ? '0 : blk_q + 1'b1;
        if (blk_end) begin
          frame_end_o = 1'b1;
          line_d      = '0;
          state_d     = en_i ? ST_VSYNC : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign state_o    = state_q;
  assign phase_o    = pix_q[0];
  assign vs_start_o = (state_q == ST_VSYNC) && (blk_q == '0);

endmodule

// File: rtl/ui_dvp_rgb565_tx.sv
// RGB565 pixel stream to 8-bit DVP (vsync/href/data) transmitter top: pixel
// handshake, low-byte holding register, registered byte mux and underrun flag.
module ui_dvp_rgb565_tx
  import ui_dvp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 144,
  parameter int VS_WIDTH = 4,
  parameter int VS_BACK  = 16,
  parameter int VS_FRONT = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  ui_dvp_rgb565_tx_if.slave        dvp,
  output logic                     frame_done_o,
  output logic                     underrun_o
);

  dvp_state_e tg_state;
  logic       tg_phase;
  logic       tg_line_end;
  logic       tg_frame_end;
  logic       tg_vs_start;

  ui_dvp_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_BLANK  (H_BLANK),
    .VS_WIDTH (VS_WIDTH),
    .VS_BACK  (VS_BACK),
    .VS_FRONT (VS_FRONT)
  ) u_timing (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .state_o     (tg_state),
    .phase_o     (tg_phase),
    .line_end_o  (tg_line_end),
    .frame_end_o (tg_frame_end),
    .vs_start_o  (tg_vs_start)
  );

  logic       vsync_q, vsync_d;
  logic       href_q, href_d;
  logic [7:0] data_q, data_d;
  logic [7:0] lo_q, lo_d;
  logic       done_q, done_d;
  logic       underrun_q, underrun_d;
  logic       ready;
  logic       starve;

  // Ready depends on timing state only, never on valid: a missing pixel costs
  // its slot (zeros on the bus) rather than stretching the line.
  assign ready  = (tg_state == ST_LINE) && !tg_phase;
  assign starve = ready && !dvp.pix_valid_i;

  always_comb begin
    vsync_d    = (tg_state == ST_VSYNC);
    href_d     = (tg_state == ST_LINE);
    done_d     = tg_frame_end;
    data_d     = 8'h00;
    lo_d       = lo_q;
    underrun_d = underrun_q;
    if (ready) begin
      data_d = dvp.pix_valid_i ? first_byte(dvp.pix_data_i)  : 8'h00;
      lo_d   = dvp.pix_valid_i ? second_byte(dvp.pix_data_i) : 8'h00;
    end else if (tg_state == ST_LINE) begin
      data_d = lo_q;
    end
    if (tg_line_end) lo_d = 8'h00;
    if (tg_vs_start) underrun_d = 1'b0;
    if (starve)      underrun_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      data_q     <= 8'h00;
      lo_q       <= 8'h00;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      vsync_q    <= vsync_d;
      href_q     <= href_d;
      data_q     <= data_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign dvp.pix_ready_o  = ready;
  assign dvp.cmos_vsync_o = vsync_q;
  assign dvp.cmos_href_o  = href_q;
  assign dvp.cmos_data_o  = data_q;
  assign frame_done_o     = done_q;
  assign underrun_o       = underrun_q;

endmodule

// File: tb/tb_ui_dvp_rgb565_tx.sv
// Directed bench for ui_dvp_rgb565_tx: byte scoreboard fed at each handshake,
// plus frame-timing checks on vsync/href/frame_done run lengths.
module tb_ui_dvp_rgb565_tx;

  localparam int H_ACTIVE  = 4;
  localparam int V_ACTIVE  = 2;
  localparam int H_BLANK   = 3;
  localparam int VS_WIDTH  = 2;
  localparam int VS_BACK   = 2;
  localparam int VS_FRONT  = 2;
  localparam int DROP_SLOT = 2;

  logic clk = 1'b0;
  logic rst_i;
  logic en_i;
  logic frame_done_o;
  logic underrun_o;

  ui_dvp_rgb565_tx_if dvp ();

  ui_dvp_rgb565_tx #(
    .H_ACTIVE (H_ACTIVE), .V_ACTIVE (V_ACTIVE), .H_BLANK (H_BLANK),
    .VS_WIDTH (VS_WIDTH), .VS_BACK (VS_BACK), .VS_FRONT (VS_FRONT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .dvp          (dvp),
    .frame_done_o (frame_done_o),
    .underrun_o   (underrun_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [7:0] sb[$];
  bit         drop_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pix_val(input int k);
    return 16'h1234 + 16'(k) * 16'h4444;
  endfunction

  // Monitor + pixel source, both on the falling edge so they never race the DUT.
  initial begin : mon
    int   cyc = 0, last_vs = 0, last_href = 0;
    int   vs_run = 0, href_run = 0, rdy_frame = 0, rises = 0, pix_idx = 0;
    bit   armed = 0, prev_vs = 0, prev_href = 0, valid;
    logic [7:0]  exp_b;
    logic [15:0] px;
    dvp.pix_valid_i = 1'b1;
    dvp.pix_data_i  = pix_val(0);
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_i) begin
        sb.delete();
        armed = 0; vs_run = 0; href_run = 0; rdy_frame = 0; rises = 0;
      end else begin
        if (dvp.cmos_vsync_o) begin
          if (!prev_vs) begin
            armed = 1; rdy_frame = 0; rises = 0; vs_run = 0;
          end
          vs_run++;
          last_vs = cyc;
        end else if (prev_vs) begin
          chk("vsync_width", vs_run, VS_WIDTH);
        end

        if (dvp.cmos_href_o) begin
          if (!prev_href) begin
            if (armed) begin
              if (rises == 0) chk("vback_gap", cyc - last_vs, VS_BACK + 1);
              else            chk("hblank_gap", cyc - last_href, H_BLANK + 1);
            end
            rises++;
            href_run = 0;
          end
          href_run++;
          last_href = cyc;
          chk("sb_has_byte", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            exp_b = sb.pop_front();
            chk("dvp_byte", dvp.cmos_data_o, exp_b);
          end
        end else begin
          if (prev_href) chk("href_len", href_run, 2 * H_ACTIVE);
          chk("blank_data", dvp.cmos_data_o, 8'h00);
        end

        if (frame_done_o && armed) begin
          chk("done_pos", cyc - last_href, VS_FRONT);
          chk("ready_per_frame", rdy_frame, H_ACTIVE * V_ACTIVE);
          chk("lines_per_frame", rises, V_ACTIVE);
          chk("sb_drained", sb.size(), 0);
        end

        valid = 1;
        if (dvp.pix_ready_o) begin
          if (drop_en && rdy_frame == DROP_SLOT) valid = 0;
          rdy_frame++;
          px = pix_val(pix_idx);
          if (valid) begin
            sb.push_back(px[15:8]);
            sb.push_back(px[7:0]);
          end else begin
            sb.push_back(8'h00);
            sb.push_back(8'h00);
          end
        end
        dvp.pix_valid_i = valid;
        dvp.pix_data_i  = pix_val(pix_idx);
        if (dvp.pix_ready_o && valid) pix_idx++;
      end
      prev_vs   = dvp.cmos_vsync_o;
      prev_href = dvp.cmos_href_o;
    end
  end

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = frame_done_o;
    end
    chk(tag, seen, 1);
  endtask

  task automatic wait_vsync(input string tag);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = dvp.cmos_vsync_o;
    end
    chk(tag, seen, 1);
  endtask

  task automatic wait_href_rises(input int n, input string tag);
    int cnt = 0;
    bit prev = dvp.cmos_href_o;
    for (int i = 0; i < 200 && cnt < n; i++) begin
      @(negedge clk);
      if (dvp.cmos_href_o && !prev) cnt++;
      prev = dvp.cmos_href_o;
    end
    chk(tag, cnt, n);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vsync"}, dvp.cmos_vsync_o, 0);
    chk({tag, "_href"},  dvp.cmos_href_o, 0);
    chk({tag, "_data"},  dvp.cmos_data_o, 8'h00);
    chk({tag, "_ready"}, dvp.pix_ready_o, 0);
    chk({tag, "_done"},  frame_done_o, 0);
  endtask

  initial begin : stim
    rst_i = 1'b1;
    en_i  = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_underrun", underrun_o, 0);

    // Out of reset with en low: must sit in IDLE.
    rst_i = 1'b0;
    repeat (5) @(negedge clk);
    chk_idle("idle_no_en");

    // Nominal frame, en held so the next frame follows immediately.
    en_i = 1'b1;
    wait_done("frame1_done");
    chk("frame1_underrun", underrun_o, 0);
    drop_en = 1'b1;
    @(negedge clk);
    chk("back_to_back_vsync", dvp.cmos_vsync_o, 1);

    // Frame 2: third pixel of line 0 missing.
    wait_done("frame2_done");
    chk("underrun_sticky", underrun_o, 1);
    drop_en = 1'b0;
    @(negedge clk);
    chk("frame3_vsync", dvp.cmos_vsync_o, 1);
    chk("underrun_cleared", underrun_o, 0);

    // Frame 3: en dropped during line 1, frame must still finish.
    wait_href_rises(2, "frame3_line1");
    en_i = 1'b0;
    wait_done("frame3_done");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_idle("after_en_drop");
    end

    // Reset in the middle of a line.
    en_i = 1'b1;
    wait_href_rises(1, "frame4_line0");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_i = 1'b1;
    #1 chk_idle("mid_line_reset");
    repeat (2) @(negedge clk);
    chk_idle("held_reset");
    rst_i = 1'b0;
    wait_vsync("restart_vsync");
    en_i = 1'b0;
    wait_done("frame5_done");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("final_idle");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
